// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle multiply/divide unit with its own busy sequencer and HI/LO registers.
// The result is computed at the start edge and held in pend_hi/pend_lo until the latency expires.
module mdu_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  mdu_op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        exc_cancel,
    input  logic        rd_hi,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);
    localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t             state, state_n;
    logic [CW-1:0]      cnt;
    logic [31:0]        pend_hi, pend_lo;
    logic               is_mul, sdiv;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        ua, ub, uq, ur, q, r;

    assign is_mul  = mdu_op == 3'd1 || mdu_op == 3'd2;
    assign sdiv    = mdu_op == 3'd3;
    assign start   = mdu_op inside {[3'd1:3'd4]} && !exc_cancel && state == IDLE;
    assign rd_data = rd_hi ? hi : lo;

    assign prod_s = $signed(op_a) * $signed(op_b);
    assign prod_u = {32'b0, op_a} * {32'b0, op_b};

    // Signed division runs on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    assign ua = (sdiv && op_a[31]) ? -op_a : op_a;
    assign ub = (sdiv && op_b[31]) ? -op_b : op_b;
    assign uq = ub == '0 ? '0 : ua / ub;
    assign ur = ub == '0 ? '0 : ua % ub;
    assign q  = (sdiv && (op_a[31] ^ op_b[31])) ? -uq : uq;
    assign r  = (sdiv && op_a[31]) ? -ur : ur;

    always_comb begin
        state_n = state;
        if (start)
            state_n = is_mul ? MUL : DIV;
        else if (state != IDLE && cnt == '0)
            state_n = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
        end else begin
            state <= state_n;
            if (start) begin
                // Divide-by-zero re-commits the current HI/LO so they appear unchanged.
                {pend_hi, pend_lo} <= is_mul ? (mdu_op == 3'd1 ? prod_s : prod_u)
                                             : (ub == '0 ? {hi, lo} : {r, q});
                cnt  <= is_mul ? CW'(MULT_CYCLES - 1) : CW'(DIV_CYCLES - 1);
                busy <= 1'b1;
            end else if (state != IDLE) begin
                if (cnt != '0) begin
                    cnt <= cnt - CW'(1);
                end else begin
                    hi   <= pend_hi;
                    lo   <= pend_lo;
                    busy <= 1'b0;
                end
            end else if (!exc_cancel) begin
                if (mdu_op == 3'd5) hi <= op_a;
                if (mdu_op == 3'd6) lo <= op_a;
            end
        end
    end
endmodule
